// File: rtl/w0rm_dbus_pkg.sv
// Shared definitions for the W0RM data-bus RAM target: FSM encoding,
// read-latency bounds and latency-counter sizing.
package w0rm_dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_RESPOND   = 2'd2
    } dbus_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CNT_W  = 3;

    typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

    // Counter preload for a freshly accepted read; zero when data is due next cycle.
    function automatic lat_cnt_t lat_load(input int read_latency);
        return LAT_CNT_W'(read_latency - 1);
    endfunction

endpackage

// File: rtl/w0rm_dbus_ram_array.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x DATA_WIDTH, registered read,
// write-first. Contents are never reset.
module w0rm_dbus_ram_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // rdata only moves on an access, so a read result stays stable while the target waits.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/w0rm_dbus_ram_target.sv
// W0RM data-bus target backed by on-chip RAM with programmable read latency.
// Define W0RM_DBUS_RAM_WRITE_ACK_EN to acknowledge writes with a zero-data valid pulse.
module w0rm_dbus_ram_target
    import w0rm_dbus_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH_LOG2   = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_valid_in,
    input  logic                  bus_write_in,
    input  logic                  bus_read_in,
    input  logic [ADDR_WIDTH-1:0] bus_addr_in,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  bus_ready_out,
    output logic                  bus_valid_out,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output dbus_state_e           dbg_state
);

    // Handshake: a request is taken on a rising edge where bus_valid_in, bus_ready_out,
    // address select and at least one of read/write are all high; write wins over read.
    // The response is a single-cycle bus_valid_out pulse; bus_data_out is zero outside it.

    localparam int TAG_LSB = DEPTH_LOG2 + 2;

    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("w0rm_dbus_ram_target: READ_LATENCY out of range 1..4");
    end
    if (BASE_ADDR[TAG_LSB-1:0] != '0) begin : g_bad_base
        $error("w0rm_dbus_ram_target: BASE_ADDR not aligned to the window size");
    end

    dbus_state_e           state;
    lat_cnt_t              lat_cnt;
    logic                  selected;
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_addr_lsbs;

    assign selected  = (bus_addr_in[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]);
    assign accept    = bus_valid_in & bus_ready_out & selected & (bus_read_in | bus_write_in);
    assign wr_accept = accept & bus_write_in;
    assign rd_accept = accept & ~bus_write_in;

    assign unused_addr_lsbs = ^bus_addr_in[1:0];

    w0rm_dbus_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (accept),
        .we    (wr_accept),
        .addr  (bus_addr_in[TAG_LSB-1:2]),
        .wdata (bus_data_in),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            lat_cnt       <= '0;
            bus_valid_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef W0RM_DBUS_RAM_WRITE_ACK_EN
                    bus_valid_out <= wr_accept;
`else
                    bus_valid_out <= 1'b0;
`endif
                    if (rd_accept) begin
                        lat_cnt <= lat_load(READ_LATENCY);
                        if (READ_LATENCY == 1) begin
                            state         <= ST_RESPOND;
                            bus_valid_out <= 1'b1;
                        end else begin
                            state <= ST_READ_WAIT;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == lat_cnt_t'(1)) begin
                        state         <= ST_RESPOND;
                        bus_valid_out <= 1'b1;
                    end
                end
                ST_RESPOND: begin
                    state         <= ST_IDLE;
                    bus_valid_out <= 1'b0;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus_valid_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus_ready_out = (state == ST_IDLE);
    // RESPOND is only ever entered for reads, so a write-ack pulse carries zero data.
    assign bus_data_out  = (state == ST_RESPOND) ? ram_rdata : '0;
    assign dbg_state     = state;

endmodule

// File: tb/tb_w0rm_dbus_ram_target.sv
// Bench for w0rm_dbus_ram_target: directed and random bus traffic checked
// cycle by cycle against a word-array model of the RAM window.
module tb_w0rm_dbus_ram_target;
    import w0rm_dbus_pkg::*;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DL    = 10;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WORDS = 1 << DL;
`ifdef W0RM_DBUS_RAM_WRITE_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          bus_valid_in = 1'b0;
    logic          bus_write_in = 1'b0;
    logic          bus_read_in  = 1'b0;
    logic [AW-1:0] bus_addr_in  = '0;
    logic [DW-1:0] bus_data_in  = '0;
    logic          bus_ready_out;
    logic          bus_valid_out;
    logic [DW-1:0] bus_data_out;
    dbus_state_e   dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    w0rm_dbus_ram_target #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH_LOG2   (DL),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_valid_in  (bus_valid_in),
        .bus_write_in  (bus_write_in),
        .bus_read_in   (bus_read_in),
        .bus_addr_in   (bus_addr_in),
        .bus_data_in   (bus_data_in),
        .bus_ready_out (bus_ready_out),
        .bus_valid_out (bus_valid_out),
        .bus_data_out  (bus_data_out),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [DW-1:0] mem_m [WORDS];
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            ready_at = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * WORDS));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic check_outputs();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        exp_v = 1'b0;
        exp_d = '0;
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            exp_v = 1'b1;
            exp_d = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
        end
        check_eq("valid", bus_valid_out, exp_v);
        check_eq("data", bus_data_out, exp_d);
        check_eq("ready", bus_ready_out, (cyc >= ready_at));
    endtask

    // ---------------- driver ----------------
    // Inputs presented during one cycle; the model decides acceptance from its
    // own notion of readiness, then outputs of the following cycle are checked.
    task automatic drive_cycle(input logic v, input logic w, input logic r,
                               input logic [31:0] a, input logic [31:0] d);
        bit acc;
        bus_valid_in = v;
        bus_write_in = w;
        bus_read_in  = r;
        bus_addr_in  = a;
        bus_data_in  = d;
        acc = v && (cyc >= ready_at) && in_window(a) && (w || r);
        @(posedge clk);
        #1;
        if (acc) begin
            if (w) begin
                mem_m[word_of(a)] = d;
                if (ACK_EN) begin
                    exp_q.push_back('0);
                    exp_cyc_q.push_back(cyc);
                end
            end else begin
                exp_q.push_back(mem_m[word_of(a)]);
                exp_cyc_q.push_back(cyc + LAT - 1);
                ready_at = cyc + LAT;
            end
        end
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset(input int hold);
        reset        = 1'b1;
        bus_valid_in = 1'b0;
        bus_write_in = 1'b0;
        bus_read_in  = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check_eq("rst_valid", bus_valid_out, 1'b0);
        check_eq("rst_data", bus_data_out, '0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_valid", bus_valid_out, 1'b0);
            check_eq("rst_data", bus_data_out, '0);
        end
        reset    = 1'b0;
        ready_at = cyc;
        #1;
        check_eq("rst_ready", bus_ready_out, 1'b1);
        check_eq("rst_state", dbg_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic        v;
        int          kind;

        apply_reset(3);

        // Fill the whole window with back-to-back writes.
        for (int i = 0; i < WORDS; i++) drive_cycle(1'b1, 1'b1, 1'b0, BASE + 32'(4 * i), $urandom);
        idle(2);

        // Basic write then read; low address bits ignored.
        drive_cycle(1'b1, 1'b1, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF);
        drive_cycle(1'b1, 1'b0, 1'b1, BASE + 32'h13, 32'h0);
        idle(LAT + 1);

        // Outside the window: no response, FSM remains idle.
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        check_eq("oow_state_lo", dbg_state, ST_IDLE);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678);
        check_eq("oow_state_hi", dbg_state, ST_IDLE);
        idle(2);

        // Top word of the window.
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h0000_1FFC, 32'h0);
        idle(LAT + 1);

        // Back-to-back writes to one word, then read; strobe-only request ignored.
        drive_cycle(1'b1, 1'b1, 1'b0, BASE + 32'h40, 32'h1);
        drive_cycle(1'b1, 1'b1, 1'b0, BASE + 32'h40, 32'h2);
        drive_cycle(1'b1, 1'b0, 1'b1, BASE + 32'h40, 32'h0);
        idle(LAT + 1);
        drive_cycle(1'b1, 1'b0, 1'b0, BASE + 32'h40, 32'h0);
        drive_cycle(1'b1, 1'b1, 1'b1, BASE + 32'h44, 32'hCAFE_0001);
        drive_cycle(1'b1, 1'b0, 1'b1, BASE + 32'h44, 32'h0);
        idle(LAT + 1);

        // Read held through the stall is taken once per ready window.
        for (int i = 0; i < 2 * (LAT + 1); i++) drive_cycle(1'b1, 1'b0, 1'b1, BASE + 32'h80, 32'h0);
        idle(LAT + 1);

        // Reset two cycles into a read: no response, RAM contents survive.
        drive_cycle(1'b1, 1'b0, 1'b1, BASE + 32'h10, 32'h0);
        idle(1);
        apply_reset(2);
        idle(LAT + 1);
        drive_cycle(1'b1, 1'b0, 1'b1, BASE + 32'h10, 32'h0);
        idle(LAT + 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 8)
                a = BASE + 32'($urandom_range(0, WORDS - 1) << 2) + 32'($urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 0)
                a = 32'($urandom_range(0, 32'h0FFF));
            else
                a = 32'h0000_2000 + 32'($urandom_range(0, 32'hFFFF));
            drive_cycle(v, (kind <= 3) || (kind == 8), ((kind >= 4) && (kind <= 8)), a, $urandom);
        end
        idle(LAT + 2);
        check_eq("drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
